// File: rtl/fetch_decode_stage.sv
// ---------------------------------------------------------------------------
// fetch_decode_stage
//   Instruction fetch unit and IF/ID pipeline register for the RV32I core.
//   Owns the PC and keeps at most one word fetch outstanding to instruction
//   memory. Presents {pc, pc+4, instruction} to decode. Supports a hazard
//   stall (IF/ID held, next word parked in a one-entry hold buffer) and a
//   branch/jump redirect from EX that flushes IF/ID and refetches.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/imem_addr    fetch request and word-aligned byte address
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     fetch response
//   stall_i               hold IF/ID contents
//   redirect_i/_pc_i      flush and refetch from redirect_pc_i (bits [1:0] ignored)
//   ifid_valid/pc/pc4/instr  IF/ID register outputs to decode
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | one bubble after reset
// FETCH | request presented at pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | response parked in hold buffer while decode is stalled
// DRAIN | one stale response still to arrive; it is discarded
// ---------------------------------------------------------------------------
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;   // address of the word currently in flight
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] redirect_target;

  logic        pc_adv;
  logic        load_rsp;     // response goes straight into IF/ID
  logic        load_hold;    // hold buffer goes into IF/ID
  logic        capture_hold; // response parked in hold buffer

  assign redirect_target = redirect_pc_i & ~32'h3;
  assign imem_addr       = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    pc_adv       = 1'b0;
    load_rsp     = 1'b0;
    load_hold    = 1'b0;
    capture_hold = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          pc_adv  = 1'b1;
          // a granted request cannot be recalled, so its response must be drained
          state_d = redirect_i ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_i) begin
            state_d = S_FETCH;
          end else if (stall_i) begin
            capture_hold = 1'b1;
            state_d      = S_HOLD;
          end else begin
            load_rsp = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (redirect_i) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_FETCH;
        end else if (!stall_i) begin
          load_hold = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DRAIN: begin
        // the awaited stale response is dropped; a redirect here only moves pc
        if (imem_rvalid) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (pc_adv) begin
        fetch_pc_q <= pc_q;
      end
      if (redirect_i) begin
        pc_q <= redirect_target;
      end else if (pc_adv) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
    end else if (redirect_i || load_hold) begin
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
    end else if (capture_hold) begin
      hold_pc_q    <= fetch_pc_q;
      hold_instr_q <= imem_rdata;
    end
  end

  // IF/ID: each loaded instruction is offered to decode for one unstalled
  // cycle; with nothing new to load the stage falls back to a NOP bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= PC_STEP;
      ifid_instr <= NOP_INSTR;
    end else if (redirect_i) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (load_rsp) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= fetch_pc_q;
      ifid_pc4   <= fetch_pc_q + PC_STEP;
      ifid_instr <= imem_rdata;
    end else if (load_hold) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= hold_pc_q;
      ifid_pc4   <= hold_pc_q + PC_STEP;
      ifid_instr <= hold_instr_q;
    end else if (!stall_i) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end
  end

  // a response is only legal while one is outstanding
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;

  int checks = 0;
  int fails = 0;
  int budget = 0;        // grants the memory model will still give
  int rlat = 1;          // cycles from grant to rvalid
  int gcount = 0;
  logic [63:0] sb_q[$];  // expected {pc, instr} entries in IF/ID
  logic [31:0] gaddr_q[$];

  bit          pend = 0;
  int          pcnt = 0;
  logic [31:0] paddr = 32'h0;
  logic        p_stall = 1'b0, p_valid = 1'b0, p_rst = 1'b0;
  logic [63:0] exp_e;
  int          g0;

  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr)
  );

  initial forever #5 clk = ~clk;

  // memory model: mem[word index] = word index
  initial begin
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pcnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = paddr >> 2;
          pend        = 0;
        end else begin
          pcnt--;
        end
      end
      imem_gnt = (budget > 0);
      if (imem_req && imem_gnt && rst_n) begin
        pend  = 1;
        pcnt  = rlat;
        paddr = imem_addr;
        budget--;
      end
    end
  end

  // monitor: logs grants, pops scoreboard on every new IF/ID entry
  initial begin
    forever begin
      @(posedge clk);
      p_stall = stall_i;
      p_valid = ifid_valid;
      p_rst   = rst_n;
      if (rst_n && imem_req && imem_gnt) begin
        gaddr_q.push_back(imem_addr);
        gcount++;
      end
      @(negedge clk);
      if (p_rst && ifid_valid && (!p_stall || !p_valid)) begin
        if (sb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_entry: got pc=%h instr=%h, expected none", ifid_pc, ifid_instr);
        end else begin
          exp_e = sb_q.pop_front();
          checks++;
          if (ifid_pc !== exp_e[63:32]) begin
            fails++;
            $display("FAIL ifid_pc: got %h expected %h", ifid_pc, exp_e[63:32]);
          end
          checks++;
          if (ifid_pc4 !== exp_e[63:32] + 32'd4) begin
            fails++;
            $display("FAIL ifid_pc4: got %h expected %h", ifid_pc4, exp_e[63:32] + 32'd4);
          end
          checks++;
          if (ifid_instr !== exp_e[31:0]) begin
            fails++;
            $display("FAIL ifid_instr: got %h expected %h (pc %h)", ifid_instr, exp_e[31:0], exp_e[63:32]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n = 1'b0; budget = 0; rlat = 1;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h expected 0", ifid_pc); end
    checks++; if (ifid_pc4 !== 32'h4) begin fails++; $display("FAIL rst_pc4: got %h expected 4", ifid_pc4); end
    checks++; if (ifid_instr !== NOP) begin fails++; $display("FAIL rst_instr: got %h expected %h", ifid_instr, NOP); end
  endtask

  task automatic test_sequential;
    gaddr_q.delete();
    sb_q.push_back({32'h0, 32'h0});
    sb_q.push_back({32'h4, 32'h1});
    sb_q.push_back({32'h8, 32'h2});
    budget = 3;
    rst_n = 1'b1;
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL seq_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 3 || gaddr_q[0] !== 32'h0 || gaddr_q[1] !== 32'h4 || gaddr_q[2] !== 32'h8) begin
      fails++; $display("FAIL seq_addrs: got %0d grants, expected 0,4,8", gaddr_q.size());
    end
  endtask

  task automatic test_stall;
    bit seen;
    gaddr_q.delete();
    sb_q.push_back({32'hC, 32'h3});
    sb_q.push_back({32'h10, 32'h4});
    sb_q.push_back({32'h14, 32'h5});
    budget = 3;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ifid_valid && (ifid_pc == 32'hC);
    end
    checks++; if (!seen) begin fails++; $display("FAIL stall_setup: got no entry at pc c, expected one"); end
    stall_i = 1'b1;
    g0 = gcount;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'hC, 32'h3}) begin
        fails++; $display("FAIL stall_frozen[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=c instr=3", i, ifid_valid, ifid_pc, ifid_instr);
      end
    end
    stall_i = 1'b0;
    checks++; if (gcount - g0 != 1) begin fails++; $display("FAIL stall_one_req: got %0d requests, expected 1", gcount - g0); end
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL stall_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 3 || gaddr_q[0] !== 32'hC || gaddr_q[1] !== 32'h10 || gaddr_q[2] !== 32'h14) begin
      fails++; $display("FAIL stall_addrs: got %0d grants, expected c,10,14", gaddr_q.size());
    end
  endtask

  task automatic test_redirect;
    gaddr_q.delete();
    rlat = 3; budget = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_wait: got req=%b expected 0", imem_req); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
      fails++; $display("FAIL redir_flush: got v=%b instr=%h expected v=0 instr=%h", ifid_valid, ifid_instr, NOP);
    end
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin fails++; $display("FAIL redir_addr: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
    rlat = 1; budget = 2;
    sb_q.push_back({32'h100, 32'h40});
    sb_q.push_back({32'h104, 32'h41});
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL redir_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 3 || gaddr_q[0] !== 32'h18 || gaddr_q[1] !== 32'h100 || gaddr_q[2] !== 32'h104) begin
      fails++; $display("FAIL redir_addrs: got %0d grants, expected 18,100,104", gaddr_q.size());
    end
  endtask

  task automatic test_redirect_stall;
    bit seen;
    budget = 1;
    sb_q.push_back({32'h108, 32'h42});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ifid_valid && (ifid_pc == 32'h108);
    end
    checks++; if (!seen) begin fails++; $display("FAIL rs_setup: got no entry at pc 108, expected one"); end
    stall_i = 1'b1;
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL rs_held: got v=%b expected 1", ifid_valid); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    redirect_i = 1'b0; stall_i = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
      fails++; $display("FAIL rs_flush: got v=%b instr=%h expected v=0 instr=%h", ifid_valid, ifid_instr, NOP);
    end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin fails++; $display("FAIL rs_addr: got req=%b addr=%h expected req=1 addr=200", imem_req, imem_addr); end
    budget = 1;
    sb_q.push_back({32'h200, 32'h80});
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL rs_drain: %0d entries missing, expected 0", sb_q.size()); end
  endtask

  task automatic test_gnt_hold;
    gaddr_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h204}) begin
        fails++; $display("FAIL gnt_hold[%0d]: got req=%b addr=%h expected req=1 addr=204", i, imem_req, imem_addr);
      end
      if (i == 2) begin redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300; end
    end
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL gnt_redir: got req=%b addr=%h expected req=1 addr=300", imem_req, imem_addr); end
    budget = 1;
    sb_q.push_back({32'h300, 32'hC0});
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL gnt_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 1 || gaddr_q[0] !== 32'h300) begin
      fails++; $display("FAIL gnt_addrs: got %0d grants, expected only 300", gaddr_q.size());
    end
  endtask

  task automatic test_reset_mid;
    gaddr_q.delete();
    rlat = 3; budget = 1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req, ifid_valid} !== 2'b00) begin fails++; $display("FAIL rmid_rst: got req=%b v=%b expected 0 0", imem_req, ifid_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; rlat = 1; budget = 1;
    sb_q.push_back({32'h0, 32'h0});
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL rmid_addr: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL rmid_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 2 || gaddr_q[0] !== 32'h304 || gaddr_q[1] !== 32'h0) begin
      fails++; $display("FAIL rmid_addrs: got %0d grants, expected 304,0", gaddr_q.size());
    end
  endtask

  task automatic test_wrap;
    gaddr_q.delete();
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin fails++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
    budget = 2;
    sb_q.push_back({32'hFFFF_FFFC, 32'h3FFF_FFFF});
    sb_q.push_back({32'h0, 32'h0});
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL wrap_drain: %0d entries missing, expected 0", sb_q.size()); end
    checks++;
    if (gaddr_q.size() != 2 || gaddr_q[0] !== 32'hFFFF_FFFC || gaddr_q[1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addrs: got %0d grants, expected fffffffc,0", gaddr_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_gnt_hold;
    test_reset_mid;
    test_wrap;
    repeat (4) @(negedge clk);
    checks++; if (sb_q.size() != 0) begin fails++; $display("FAIL final_sb: %0d entries left, expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
